// File: rtl/frame_sequencer.sv
// Frame protocol controller between the UART and the image filter: parses the
// SYNC/command header, streams pixels to the filter and appends the ACK+checksum or NAK trailer.
module frame_sequencer #(
  parameter int unsigned       row_depth      = 450,
  parameter int unsigned       column_depth   = 500,
  parameter int unsigned       D_BITS         = 8,
  parameter int unsigned       timeout_cycles = 10_000000,
  parameter logic [D_BITS-1:0] SYNC           = 8'hA5,
  parameter logic [D_BITS-1:0] ACK            = 8'h5A,
  parameter logic [D_BITS-1:0] NAK            = 8'hEE
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [D_BITS-1:0] i_rx_data,
  input  logic              i_rx_dvalid,
  output logic [D_BITS-1:0] o_pix_data,
  output logic              o_pix_valid,
  output logic [1:0]        o_filt_sel,
  input  logic [D_BITS-1:0] i_filt_data,
  input  logic              i_filt_dvalid,
  output logic              o_filt_tx_rdy,
  input  logic              i_tx_rdy,
  output logic [D_BITS-1:0] o_tx_data,
  output logic              o_tx_enable,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned N  = row_depth * column_depth;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned WW = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [WW-1:0] TO_C = WW'(timeout_cycles);

  typedef enum logic [2:0] {
    IDLE, CMD, LOAD, DRAIN, SEND_ACK, SEND_CSUM, SEND_NAK
  } state_t;

  typedef enum logic {WAIT_RDY, WAIT_LOW} phase_t;

  state_t            state;
  phase_t            phase;
  logic [CW-1:0]     in_cnt;
  logic [CW-1:0]     out_cnt;
  logic [WW-1:0]     wd;
  logic [D_BITS-1:0] checksum;
  logic [D_BITS-1:0] tx_data_q;
  logic              tx_en_q;
  logic [D_BITS-1:0] send_byte;
  logic              filt_owns;
  logic              out_done;
  logic              wd_hit;

  assign filt_owns = (state == LOAD) || (state == DRAIN);

  // The filter drives TX directly while it owns the channel; otherwise the registered trailer path does.
  assign o_filt_tx_rdy = filt_owns & i_tx_rdy;
  assign o_tx_data     = filt_owns ? i_filt_data : tx_data_q;
  assign o_tx_enable   = filt_owns ? i_filt_dvalid : tx_en_q;
  assign o_busy        = (state != IDLE);

  // The last filter byte completes the frame on its own cycle so out_cnt can never pass N.
  assign out_done = (out_cnt == N_C) ||
                    (i_filt_dvalid && (out_cnt == N_C - 1'b1));
  assign wd_hit   = !i_filt_dvalid && (wd == TO_C - 1'b1);

  always_comb begin
    send_byte = NAK;
    if (state == SEND_ACK)
      send_byte = ACK;
    else if (state == SEND_CSUM)
      send_byte = checksum;
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= WAIT_RDY;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wd          <= '0;
      checksum    <= '0;
      o_pix_data  <= '0;
      o_pix_valid <= 1'b0;
      o_filt_sel  <= '0;
      o_err       <= 1'b0;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
    end else begin
      o_pix_valid <= 1'b0;
      tx_en_q     <= 1'b0;

      if (i_filt_dvalid) begin
        if (filt_owns) begin
          if (out_cnt != N_C) begin
            out_cnt  <= out_cnt + 1'b1;
            checksum <= checksum ^ i_filt_data;
          end
        end else begin
          o_err <= 1'b1;
        end
        wd <= '0;
      end else if (state == DRAIN) begin
        wd <= wd + 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_rx_dvalid && (i_rx_data == SYNC)) begin
            state <= CMD;
            o_err <= 1'b0;
          end
        end
        CMD: begin
          if (i_rx_dvalid) begin
            if (i_rx_data[D_BITS-1:2] == '0) begin
              o_filt_sel <= i_rx_data[1:0];
              in_cnt     <= '0;
              out_cnt    <= '0;
              checksum   <= '0;
              wd         <= '0;
              state      <= LOAD;
            end else begin
              o_err <= 1'b1;
              state <= SEND_NAK;
            end
          end
        end
        LOAD: begin
          if (i_rx_dvalid) begin
            o_pix_data  <= i_rx_data;
            o_pix_valid <= 1'b1;
            in_cnt      <= in_cnt + 1'b1;
            if (in_cnt == N_C - 1'b1)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_rx_dvalid)
            o_err <= 1'b1;
          if (out_done) begin
            state <= SEND_ACK;
          end else if (wd_hit) begin
            o_err <= 1'b1;
            state <= SEND_NAK;
          end
        end
        SEND_ACK, SEND_CSUM, SEND_NAK: begin
          if (i_rx_dvalid)
            o_err <= 1'b1;
          if (phase == WAIT_RDY) begin
            if (i_tx_rdy) begin
              tx_data_q <= send_byte;
              tx_en_q   <= 1'b1;
              phase     <= WAIT_LOW;
            end
          end else if (!i_tx_rdy && !tx_en_q) begin
            phase <= WAIT_RDY;
            state <= (state == SEND_ACK) ? SEND_CSUM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: echo-filter and UART models, a TX scoreboard,
// a table of frames plus hand-written noise, stray-byte, TX-hold and mid-frame reset sequences.
module tb_frame_sequencer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h5A;
  localparam logic [7:0] NAK  = 8'hEE;

  typedef struct {
    logic [7:0]  cmd;
    logic [47:0] pix;
    int unsigned ret;
    logic [1:0]  sel;
    logic        nak;
    logic [7:0]  csum;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_dvalid;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic [1:0] filt_sel;
  logic [7:0] filt_data;
  logic       filt_dvalid;
  logic       filt_tx_rdy;
  logic       tx_rdy;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       busy;
  logic       err;

  frame_sequencer #(
    .row_depth(2),
    .column_depth(3),
    .timeout_cycles(50)
  ) dut (
    .i_clk(clk),
    .reset(rst_n),
    .i_rx_data(rx_data),
    .i_rx_dvalid(rx_dvalid),
    .o_pix_data(pix_data),
    .o_pix_valid(pix_valid),
    .o_filt_sel(filt_sel),
    .i_filt_data(filt_data),
    .i_filt_dvalid(filt_dvalid),
    .o_filt_tx_rdy(filt_tx_rdy),
    .i_tx_rdy(tx_rdy),
    .o_tx_data(tx_data),
    .o_tx_enable(tx_enable),
    .o_busy(busy),
    .o_err(err)
  );

  // controls driven by the stimulus process
  logic        filt_en;
  logic        filt_clr;
  int unsigned filt_limit;
  int unsigned filt_gap;
  logic        uart_hold;
  logic        in_hold;

  // model state
  int unsigned cyc = 0;
  logic [7:0]  echo_q[$];
  int unsigned filt_sent;
  int unsigned gap_cnt;
  int unsigned pix_cnt;
  int unsigned last_filt_cyc;
  int unsigned ucnt;

  // checking state
  logic [7:0]  exp_tx[$];
  int unsigned tx_seen;
  int unsigned frdy_hi;
  int unsigned nak_cyc;
  int          total;
  int          bad;
  vec_t        vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  // Echo filter: returns each pixel once, only when the gated tx_rdy allows, up to filt_limit bytes.
  always @(posedge clk) begin
    if (filt_clr) begin
      echo_q.delete();
      filt_dvalid <= 1'b0;
      filt_data   <= 8'h00;
      filt_sent   <= 0;
      gap_cnt     <= 0;
      pix_cnt     <= 0;
    end else begin
      filt_dvalid <= 1'b0;
      if (pix_valid) begin
        echo_q.push_back(pix_data);
        pix_cnt <= pix_cnt + 1;
      end
      if (gap_cnt != 0)
        gap_cnt <= gap_cnt - 1;
      else if (filt_en && !filt_dvalid && filt_tx_rdy && echo_q.size() != 0 &&
               filt_sent < filt_limit) begin
        filt_data     <= echo_q.pop_front();
        filt_dvalid   <= 1'b1;
        filt_sent     <= filt_sent + 1;
        gap_cnt       <= filt_gap;
        last_filt_cyc <= cyc;
      end
    end
  end

  // UART TX: drops rdy after a start, stays busy a few cycles, optionally held busy.
  always @(posedge clk) begin
    if (!rst_n) begin
      tx_rdy <= 1'b1;
      ucnt   <= 0;
    end else if (tx_rdy && tx_enable) begin
      tx_rdy <= 1'b0;
      ucnt   <= 3;
    end else if (!tx_rdy) begin
      if (ucnt != 0)
        ucnt <= ucnt - 1;
      else if (!uart_hold)
        tx_rdy <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rx(input logic [7:0] b, input bit is_pix);
    @(negedge clk);
    rx_data   = b;
    rx_dvalid = 1'b1;
    @(negedge clk);
    rx_dvalid = 1'b0;
    if (is_pix) begin
      chk("pix_valid", pix_valid, 1);
      chk("pix_data", pix_data, b);
    end else begin
      chk("no_pix", pix_valid, 0);
    end
  endtask

  task automatic clear_filter(input int unsigned lim, input int unsigned gap);
    filt_limit = lim;
    filt_gap   = gap;
    @(negedge clk);
    filt_clr = 1'b1;
    @(negedge clk);
    filt_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_tx.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL wait_idle: busy=%0b pending=%0d after %0d cycles, required idle",
               busy, exp_tx.size(), n);
    end
  endtask

  // mode 0: plain frame, 1: hold UART busy at trailer time, 2: stray RX byte in DRAIN
  task automatic run_frame(input vec_t v, input int unsigned gap, input int mode);
    logic [7:0]  b;
    int unsigned t0;
    int unsigned f0;
    int          n;
    clear_filter(v.nak ? 0 : v.ret, gap);
    t0 = tx_seen;
    f0 = frdy_hi;
    rx(SYNC, 0);
    if (v.nak) begin
      exp_tx.push_back(NAK);
      rx(v.cmd, 0);
    end else begin
      rx(v.cmd, 0);
      for (int i = 0; i < 6; i++) begin
        b = v.pix[i*8 +: 8];
        if (i < v.ret)
          exp_tx.push_back(b);
        rx(b, 1);
      end
      chk("filt_sel", filt_sel, v.sel);
      if (v.ret == 6) begin
        exp_tx.push_back(ACK);
        exp_tx.push_back(v.csum);
      end else begin
        exp_tx.push_back(NAK);
      end
      if (mode == 2) begin
        rx(8'h77, 0);
        chk("stray_err", err, 1);
        chk("stray_busy", busy, 1);
      end
      if (mode == 1) begin
        n = 0;
        while (filt_sent < 6 && n < 500) begin
          @(negedge clk);
          #1;
          n++;
        end
        chk("hold_reach_drain", n < 500, 1);
        uart_hold = 1'b1;
        in_hold   = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        chk("hold_tx_count", tx_seen - t0, 6);
        chk("hold_filt_rdy", frdy_hi - f0, 0);
        chk("hold_busy", busy, 1);
        in_hold   = 1'b0;
        uart_hold = 1'b0;
      end
    end
    wait_idle(3000);
    chk("frame_err", err, v.err | (mode == 2));
    chk("pix_count", pix_cnt, v.nak ? 0 : 6);
    if (mode == 1)
      chk("hold_tx_total", tx_seen - t0, 8);
    if (!v.nak && v.ret < 6) begin
      chk("timeout_min", (nak_cyc - last_filt_cyc) >= 50, 1);
      chk("timeout_max", (nak_cyc - last_filt_cyc) <= 120, 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    vecs[0] = '{8'h01, 48'h60_50_40_30_20_10, 6, 2'd1, 1'b0, 8'h70, 1'b0};
    vecs[1] = '{8'h84, 48'h0,                 0, 2'd0, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 48'h66_55_44_33_22_11, 6, 2'd0, 1'b0, 8'h77, 1'b0};
    vecs[3] = '{8'h03, 48'h85_84_83_82_81_80, 5, 2'd3, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h02, 48'hFF_00_55_AA_F0_0F, 6, 2'd2, 1'b0, 8'hFF, 1'b0};

    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_dvalid  = 1'b0;
    filt_en    = 1'b1;
    filt_clr   = 1'b1;
    filt_limit = 0;
    filt_gap   = 2;
    uart_hold  = 1'b0;
    in_hold    = 1'b0;
    tx_seen    = 0;
    frdy_hi    = 0;
    nak_cyc    = 0;
    total      = 0;
    bad        = 0;

    fork
      begin : monitor
        logic [7:0] e;
        forever begin
          @(negedge clk);
          if (tx_enable) begin
            tx_seen++;
            chk("tx_start_rdy", tx_rdy, 1);
            if (exp_tx.size() == 0) begin
              total++;
              bad++;
              $display("FAIL tx_unexpected: got %h, required no transmission (t=%0t)",
                       tx_data, $time);
            end else begin
              e = exp_tx.pop_front();
              chk("tx_byte", tx_data, e);
            end
            if (tx_data == NAK)
              nak_cyc = cyc;
          end
          if (in_hold && filt_tx_rdy)
            frdy_hi++;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_filt_tx_rdy", filt_tx_rdy, 0);
    chk("rst_filt_sel", filt_sel, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n    = 1'b1;
    filt_clr = 1'b0;

    rx(8'h00, 0);
    chk("noise_busy0", busy, 0);
    rx(8'hFF, 0);
    chk("noise_busy1", busy, 0);
    chk("noise_err", err, 0);
    chk("idle_filt_rdy", filt_tx_rdy, 0);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i], 2, 0);

    run_frame(vecs[0], 20, 2);
    run_frame(vecs[0], 2, 1);

    clear_filter(6, 2);
    rx(SYNC, 0);
    rx(8'h01, 0);
    for (int i = 0; i < 3; i++) begin
      b = vecs[0].pix[i*8 +: 8];
      exp_tx.push_back(b);
      rx(b, 1);
    end
    #1;
    rst_n   = 1'b0;
    filt_en = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_pix_valid", pix_valid, 0);
    chk("mid_tx_enable", tx_enable, 0);
    chk("mid_filt_tx_rdy", filt_tx_rdy, 0);
    chk("mid_filt_sel", filt_sel, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_pix_data", pix_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_err", err, 0);
    rst_n = 1'b1;
    exp_tx.delete();
    repeat (30) @(negedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err, 0);
    clear_filter(6, 2);
    filt_en = 1'b1;
    run_frame(vecs[0], 2, 0);
    run_frame(vecs[4], 2, 0);

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Protocol controller between uart_modul and filtre_modul. It parses a 2-byte frame header from the UART RX stream, selects the filter mode, and forwards exactly row_depth*column_depth pixel bytes to the filter.
- It counts the filtered bytes the filter returns and arbitrates the single UART TX channel between filter output and its own trailer bytes: ACK plus XOR checksum, or NAK.
- Sits in top_modul, in series on the rx_data/rx_dvalid path and the tx_data/tx_enable/tx_rdy path.

Parameters:
- row_depth, 450, image rows.
- column_depth, 500, image columns.
- D_BITS, 8, byte width.
- timeout_cycles, 10_000000, maximum i_clk cycles between filter output bytes in DRAIN.
- SYNC, 8'hA5, frame start byte.
- ACK, 8'h5A, success trailer byte.
- NAK, 8'hEE, error trailer byte.

Ports:
- i_clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- i_rx_data  in  D_BITS  byte from UART RX.
- i_rx_dvalid  in  1  1-cycle strobe, i_rx_data valid.
- o_pix_data  out  D_BITS  pixel byte to filter.
- o_pix_valid  out  1  1-cycle strobe to filter i_drdy.
- o_filt_sel  out  2  filter mode, held stable for the whole frame.
- i_filt_data  in  D_BITS  filter output byte.
- i_filt_dvalid  in  1  filter output strobe.
- o_filt_tx_rdy  out  1  gated tx_rdy to filter i_tx_rdy.
- i_tx_rdy  in  1  UART TX idle.
- o_tx_data  out  D_BITS  byte to UART TX.
- o_tx_enable  out  1  1-cycle TX start strobe.
- o_busy  out  1  high in every state except IDLE.
- o_err  out  1  sticky error flag.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; all counters 0; checksum 0.
  - o_pix_valid=0, o_tx_enable=0, o_filt_tx_rdy=0, o_filt_sel=0, o_tx_data=0, o_pix_data=0, o_busy=0, o_err=0.
  - Reset mid-frame aborts immediately; no trailer is sent.
- N = row_depth*column_depth. Counters in_cnt and out_cnt are $clog2(N+1) bits wide. They never wrap; comparison is against N.
- IDLE:
  - On i_rx_dvalid with i_rx_data==SYNC: go to CMD and clear o_err.
  - Any other byte is ignored.
- CMD (next RX byte):
  - If bits[7:2]==0: latch o_filt_sel=bits[1:0], clear in_cnt, out_cnt and checksum, go to LOAD.
  - Otherwise: set o_err and go to SEND_NAK.
- LOAD:
  - Each i_rx_dvalid produces o_pix_data=i_rx_data and o_pix_valid=1 on the next cycle (1-cycle latency, registered). in_cnt increments.
  - When in_cnt reaches N, go to DRAIN. Filter output is accepted in LOAD as well.
- Filter owns TX in LOAD and DRAIN:
  - o_filt_tx_rdy=i_tx_rdy, combinational.
  - o_tx_data=i_filt_data and o_tx_enable=i_filt_dvalid, combinational pass-through.
  - Each i_filt_dvalid increments out_cnt and XORs the byte into checksum.
- DRAIN:
  - Watchdog counts cycles since the last i_filt_dvalid.
  - out_cnt==N: go to SEND_ACK.
  - Watchdog reaches timeout_cycles: set o_err and go to SEND_NAK.
  - If the watchdog hit and out_cnt==N occur in the same cycle, the out_cnt==N case takes priority.
- RX bytes in DRAIN or any SEND state are dropped and set o_err. The frame continues.
- i_filt_dvalid outside LOAD/DRAIN is discarded: no TX, sets o_err. In those states o_filt_tx_rdy=0.
- out_cnt must not exceed N. An extra filter byte in DRAIN at out_cnt==N is impossible, because the transition happens on the same cycle.
- Controller byte send procedure, used by SEND_ACK, SEND_CSUM and SEND_NAK:
  - WAIT_RDY: wait for i_tx_rdy==1.
  - Drive o_tx_data=byte, o_tx_enable=1 for exactly 1 cycle.
  - WAIT_LOW: wait for i_tx_rdy==0 before the next send. This guards against a double start.
- Trailer sequences:
  - SEND_ACK sends ACK, then SEND_CSUM sends checksum, then IDLE.
  - SEND_NAK sends NAK, then IDLE.
  - o_err stays set after a NAK until the next SYNC.

Test Plan:
- Small frame (row_depth=2, column_depth=3): RX A5,01,10,20,30,40,50,60, filter echoes the bytes -> o_filt_sel=1; six o_pix_valid pulses, each 1 cycle after its RX strobe; TX shows the 6 echoed bytes, then 5A, then 70 (XOR of the bytes); o_busy low after the trailer; o_err=0.
- Bad command: A5,84 -> TX EE only; o_pix_valid never asserted; o_err=1; a following A5,00 frame clears o_err.
- Timeout (timeout_cycles=50): filter returns 5 of 6 bytes -> after 50 idle cycles TX EE, o_err=1, state IDLE.
- Noise and stray input: bytes 00,FF in IDLE -> ignored, o_busy stays 0. An RX byte injected during DRAIN -> o_err=1, frame still ends with 5A and the correct checksum.
- TX arbitration: hold i_tx_rdy=0 for 200 cycles in SEND_ACK -> o_tx_enable stays 0 until rdy rises, then exactly one pulse; o_filt_tx_rdy=0 throughout SEND states.
- Reset mid-LOAD (after 3 pixels): reset low for 1 cycle -> all outputs 0, state IDLE, no trailer; a new A5 frame completes normally.
